write_back_buffer: RTL and testbench
====================================

# write_back_buffer

Posted-write buffer between the set-associative cache and main memory. Dirty lines evicted by the cache are pushed into a small FIFO and drained to memory one at a time over a request/acknowledge handshake, so the cache never stalls on a slow write. A combinational lookup port forwards buffered data to the cache on a miss, preventing reads of stale memory while a write-back is still pending.

## Interface
- data_width, 32, width of one buffered data word
- address_width, 16, width of the write-back address
- depth, 4, number of FIFO entries; must be a power of two and at least 2
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- evict_valid  in  1  cache offers an evicted dirty word this cycle
- evict_ready  out  1  buffer accepts a push; equals !full
- evict_address  in  address_width  word address of the evicted entry
- evict_data  in  data_width  evicted data
- lookup_address  in  address_width  cache-miss address to check against buffered entries
- lookup_hit  out  1  combinational; some valid entry matches lookup_address
- lookup_data  out  data_width  data of the newest matching entry; 0 when lookup_hit=0
- mem_write_req  out  1  write request to memory, registered
- mem_address  out  address_width  address of the head entry, registered
- mem_data  out  data_width  data of the head entry, registered
- mem_ack  in  1  memory has accepted the current write
- count  out  $clog2(depth)+1  number of valid entries
- full  out  1  count == depth
- empty  out  1  count == 0

## Operation
- Push: on a rising edge with evict_valid && evict_ready, write the entry at the tail, advance the tail pointer modulo depth, increment count. evict_valid while full is ignored; no entry is written and none is lost from the FIFO.
- Same-address pushes are not coalesced; each is a separate entry, drained in order, so memory ends with the newest value.
- Lookup: compare lookup_address against every valid entry, including the head entry currently being written. On multiple matches, return the entry closest to the tail (newest).
- Drain FSM states:
  - IDLE: if !empty, latch the head entry into mem_address/mem_data, assert mem_write_req, go to WRITE.
  - WRITE: hold mem_write_req, mem_address and mem_data stable. On mem_ack=1, deassert mem_write_req and go to RETIRE.
  - RETIRE: pop the head (advance the head pointer modulo depth, decrement count), then go to IDLE.
- mem_ack outside WRITE is ignored.
- Push and pop in the same edge: count is unchanged and both pointers advance. A push while full is refused even when RETIRE pops on that edge.
- Pointers wrap modulo depth. count is the only full/empty source.

## Timing
- Reset values: mem_write_req=0, mem_address=0, mem_data=0, count=0, empty=1, full=0, evict_ready=1, lookup_hit=0, lookup_data=0. FSM goes to IDLE.
- Reset asserted mid-transfer drops mem_write_req asynchronously and discards all entries.
- Push at edge N: count, full and empty update after edge N. lookup_hit is visible after edge N.
- From empty, a push at edge N gives mem_write_req=1 after edge N+1.
- mem_ack=1 sampled at edge M: mem_write_req=0 after M, pop at edge M+1, next mem_write_req=1 after edge M+2 at the earliest.
- Minimum of 3 cycles per drained entry with zero-wait memory.

## Configuration
- WB_FLUSH_EN defined: adds input flush (1 bit) and output flush_done (1 bit, reset 0).
  - A flush pulse sets a sticky flushing flag. While the flag is set, evict_ready=0.
  - When count reaches 0 and the FSM is in IDLE, the flag clears and flush_done pulses high for exactly one cycle.
  - A flush while already empty pulses flush_done on the next edge.
- WB_FLUSH_EN undefined: the flush and flush_done ports are absent, and evict_ready is exactly !full.

## Test plan
- Reset, then push (0x0010, 0xDEADBEEF) with mem_ack tied high -> mem_write_req rises 2 edges after the push with mem_address=0x0010 and mem_data=0xDEADBEEF; count returns to 0 after RETIRE.
- Push 4 entries with mem_ack=0 -> full=1, evict_ready=0, count=4. A fifth push is ignored. Releasing mem_ack drains the entries in push order.
- Push 0x0020/0x1 then 0x0020/0x2 and look up 0x0020 -> lookup_hit=1, lookup_data=0x2. After both entries drain, lookup_hit=0.
- Hold mem_ack low for 5 cycles during WRITE -> mem_write_req, mem_address and mem_data stay constant throughout. A mem_ack pulse while IDLE has no effect.
- Assert reset during WRITE with 3 entries queued -> mem_write_req drops in the same cycle, count=0, empty=1. Subsequent pushes work normally.
- WB_FLUSH_EN: 2 entries queued, pulse flush -> evict_ready=0 until drained, then flush_done is high for one cycle and evict_ready returns to 1.

Source files
------------

// File: rtl/write_back_buffer_if.sv
// write_back_buffer_if: bundles the cache eviction port, the miss lookup port
// and the memory write handshake of the posted-write buffer.
// slave  = buffer side, master = cache/memory side.
interface write_back_buffer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              evict_valid;
    logic              evict_ready;
    logic [ADDR_W-1:0] evict_address;
    logic [DATA_W-1:0] evict_data;
    logic [ADDR_W-1:0] lookup_address;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic              mem_write_req;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ack;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport slave (
        input  evict_valid, evict_address, evict_data, lookup_address, mem_ack,
        output evict_ready, lookup_hit, lookup_data, mem_write_req, mem_address,
               mem_data, count, full, empty
    );

    modport master (
        output evict_valid, evict_address, evict_data, lookup_address, mem_ack,
        input  evict_ready, lookup_hit, lookup_data, mem_write_req, mem_address,
               mem_data, count, full, empty
    );
endinterface

// File: rtl/write_back_buffer.sv
// write_back_buffer: posted-write FIFO between the cache and main memory.
// Evicted dirty words are queued and drained one at a time over a
// request/acknowledge handshake (IDLE -> WRITE -> RETIRE). A combinational
// lookup forwards the newest buffered copy of an address on a cache miss.
// Optional feature: define WB_FLUSH_EN to add i_flush / o_flush_done.
module write_back_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
`ifdef WB_FLUSH_EN
    input  logic               i_flush,
    output logic               o_flush_done,
`endif
    write_back_buffer_if.slave io_bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        RETIRE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic              r_mem_req;
    logic              w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] w_mem_data_nxt;

    logic              w_full;
    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_data;

    // count is the single source of occupancy; pointers only address storage
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef WB_FLUSH_EN
    logic r_flushing;
    logic r_flush_done;
    logic w_flush_req;

    // a pending flush blocks new evictions until the buffer has drained
    assign w_ready     = !w_full && !r_flushing;
    assign w_flush_req = r_flushing || i_flush;
`else
    assign w_ready = !w_full;
`endif

    // a push refused when full stays refused even if RETIRE frees a slot this edge
    assign w_push = io_bus.evict_valid && w_ready;
    assign w_pop  = (r_state == RETIRE);

    // entry storage: data path only, no reset needed
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_tail] <= io_bus.evict_address;
            r_data[r_tail] <= io_bus.evict_data;
        end
    end

    // head/tail pointers wrap naturally at the power-of-two depth; count tracks fill
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // drain FSM state and registered memory request outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_data <= w_mem_data_nxt;
        end
    end

    // drain FSM next state: latch head, hold until ack, then retire the entry
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_data_nxt = r_mem_data;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_addr[r_head];
                    w_mem_data_nxt = r_data[r_head];
                    w_state_nxt    = WRITE;
                end
            end
            WRITE: begin
                if (io_bus.mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = RETIRE;
                end
            end
            RETIRE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // lookup walks entries oldest to newest so the newest match wins;
    // the head entry stays visible until it is retired
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) &&
                (r_addr[r_head + PTR_W'(k)] == io_bus.lookup_address)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[r_head + PTR_W'(k)];
            end
        end
    end

`ifdef WB_FLUSH_EN
    // sticky flush flag; clears with a one-cycle done pulse once drained and idle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flushing   <= 1'b0;
            r_flush_done <= 1'b0;
        end else if (w_flush_req && w_empty && (r_state == IDLE) && !w_push) begin
            r_flushing   <= 1'b0;
            r_flush_done <= 1'b1;
        end else begin
            r_flushing   <= w_flush_req;
            r_flush_done <= 1'b0;
        end
    end

    assign o_flush_done = r_flush_done;
`endif

    assign io_bus.evict_ready   = w_ready;
    assign io_bus.lookup_hit    = w_hit;
    assign io_bus.lookup_data   = w_hit_data;
    assign io_bus.mem_write_req = r_mem_req;
    assign io_bus.mem_address   = r_mem_addr;
    assign io_bus.mem_data      = r_mem_data;
    assign io_bus.count         = r_count;
    assign io_bus.full          = w_full;
    assign io_bus.empty         = w_empty;
endmodule

// File: tb/tb_write_back_buffer.sv
// tb_write_back_buffer: directed scenarios plus a randomized phase. A queue
// model of the buffer contents predicts occupancy and lookup results; a
// scoreboard of accepted pushes is consumed by a separate memory-side monitor.
module tb_write_back_buffer;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    write_back_buffer_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    write_back_buffer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int   n_pass = 0;
    int   n_chk  = 0;
    ent_t mq[$];       // model of buffer contents, oldest first
    ent_t exp_wr[$];   // scoreboard: expected memory writes in order
    bit   pop_pending = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic void ref_lookup(input logic [AW-1:0] a, output logic hit,
                                       output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (mq[i]) begin
            if (mq[i].a == a) begin
                hit = 1'b1;
                d   = mq[i].d;
            end
        end
    endfunction

    // reference model: update contents at each edge, then check outputs 1 time unit later
    always @(posedge clk) begin
        logic          acc;
        logic          hs;
        logic          hit;
        logic [DW-1:0] ld;
        if (rst) begin
            mq.delete();
            exp_wr.delete();
            pop_pending = 0;
        end else begin
            acc = bus.evict_valid && (mq.size() < DEPTH);
            hs  = bus.mem_write_req && bus.mem_ack;
            if (pop_pending) begin
                void'(mq.pop_front());
                pop_pending = 0;
            end
            if (acc) begin
                mq.push_back('{a: bus.evict_address, d: bus.evict_data});
                exp_wr.push_back('{a: bus.evict_address, d: bus.evict_data});
            end
            if (hs) pop_pending = 1;
            #1;
            if (!rst) begin
                chk("m_count", 64'(bus.count), 64'(mq.size()));
                chk("m_full", 64'(bus.full), 64'(mq.size() == DEPTH));
                chk("m_empty", 64'(bus.empty), 64'(mq.size() == 0));
                chk("m_ready", 64'(bus.evict_ready), 64'(mq.size() < DEPTH));
                ref_lookup(bus.lookup_address, hit, ld);
                chk("m_lookup_hit", 64'(bus.lookup_hit), 64'(hit));
                chk("m_lookup_data", 64'(bus.lookup_data), 64'(ld));
                if (bus.mem_write_req) begin
                    if (mq.size() == 0) chk("m_req_when_empty", 64'(1), 64'(0));
                    else begin
                        chk("m_req_head_addr", 64'(bus.mem_address), 64'(mq[0].a));
                        chk("m_req_head_data", 64'(bus.mem_data), 64'(mq[0].d));
                    end
                end
            end
        end
    end

    // memory-side monitor: each completed handshake must match the next expected write
    always @(posedge clk) begin
        ent_t e;
        if (!rst && bus.mem_write_req && bus.mem_ack) begin
            if (exp_wr.size() == 0) chk("drain_unexpected", 64'(1), 64'(0));
            else begin
                e = exp_wr.pop_front();
                chk("drain_addr", 64'(bus.mem_address), 64'(e.a));
                chk("drain_data", 64'(bus.mem_data), 64'(e.d));
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.evict_valid   = 1'b1;
        bus.evict_address = a;
        bus.evict_data    = d;
        @(negedge clk);
        bus.evict_valid   = 1'b0;
    endtask

    task automatic wait_empty(input int max, input string nm);
        int n = 0;
        while (!bus.empty && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(bus.empty), 64'(1));
    endtask

    task automatic wait_req(input int max, input string nm);
        int n = 0;
        while (!bus.mem_write_req && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(bus.mem_write_req), 64'(1));
    endtask

    initial begin
        logic [AW-1:0] cap_a;
        logic [DW-1:0] cap_d;

        bus.evict_valid    = 1'b0;
        bus.evict_address  = '0;
        bus.evict_data     = '0;
        bus.lookup_address = 16'h0010;
        bus.mem_ack        = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_req", 64'(bus.mem_write_req), 64'(0));
        chk("rst_addr", 64'(bus.mem_address), 64'(0));
        chk("rst_data", 64'(bus.mem_data), 64'(0));
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_empty", 64'(bus.empty), 64'(1));
        chk("rst_full", 64'(bus.full), 64'(0));
        chk("rst_ready", 64'(bus.evict_ready), 64'(1));
        chk("rst_hit", 64'(bus.lookup_hit), 64'(0));
        chk("rst_ldata", 64'(bus.lookup_data), 64'(0));
        rst = 1'b0;

        // single push with memory always ready: request two edges after the push
        bus.mem_ack = 1'b1;
        push(16'h0010, 32'hDEADBEEF);
        chk("t1_count", 64'(bus.count), 64'(1));
        chk("t1_req_early", 64'(bus.mem_write_req), 64'(0));
        chk("t1_hit", 64'(bus.lookup_hit), 64'(1));
        @(negedge clk);
        chk("t1_req", 64'(bus.mem_write_req), 64'(1));
        chk("t1_addr", 64'(bus.mem_address), 64'(16'h0010));
        chk("t1_data", 64'(bus.mem_data), 64'(32'hDEADBEEF));
        @(negedge clk);
        chk("t1_req_drop", 64'(bus.mem_write_req), 64'(0));
        chk("t1_count_hold", 64'(bus.count), 64'(1));
        @(negedge clk);
        chk("t1_count_zero", 64'(bus.count), 64'(0));
        chk("t1_empty", 64'(bus.empty), 64'(1));

        // fill to capacity, refused fifth push, ordered drain
        bus.mem_ack = 1'b0;
        for (int i = 0; i < DEPTH; i++) push(AW'(16'h0100 + i), DW'(32'hA000_0000 + i));
        chk("t2_full", 64'(bus.full), 64'(1));
        chk("t2_ready", 64'(bus.evict_ready), 64'(0));
        chk("t2_count", 64'(bus.count), 64'(4));
        push(16'h0200, 32'hBAD0BAD0);
        chk("t2_count_after5", 64'(bus.count), 64'(4));
        bus.mem_ack = 1'b1;
        wait_empty(60, "t2_drain");
        bus.mem_ack = 1'b0;

        // same-address pushes: lookup returns the newest
        bus.lookup_address = 16'h0020;
        push(16'h0020, 32'h1);
        push(16'h0020, 32'h2);
        chk("t3_hit", 64'(bus.lookup_hit), 64'(1));
        chk("t3_data", 64'(bus.lookup_data), 64'(2));
        bus.mem_ack = 1'b1;
        wait_empty(30, "t3_drain");
        bus.mem_ack = 1'b0;
        chk("t3_hit_after", 64'(bus.lookup_hit), 64'(0));
        chk("t3_data_after", 64'(bus.lookup_data), 64'(0));

        // stall in WRITE holds request stable; ack while idle is ignored
        push(16'h0033, 32'hCAFEF00D);
        wait_req(5, "t4_req_rise");
        cap_a = bus.mem_address;
        cap_d = bus.mem_data;
        chk("t4_cap_addr", 64'(cap_a), 64'(16'h0033));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_req", 64'(bus.mem_write_req), 64'(1));
            chk("t4_hold_addr", 64'(bus.mem_address), 64'(cap_a));
            chk("t4_hold_data", 64'(bus.mem_data), 64'(cap_d));
        end
        bus.mem_ack = 1'b1;
        wait_empty(10, "t4_drain");
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("t4_idle_req", 64'(bus.mem_write_req), 64'(0));
        chk("t4_idle_count", 64'(bus.count), 64'(0));
        @(negedge clk);
        chk("t4_idle_req2", 64'(bus.mem_write_req), 64'(0));

        // asynchronous reset in the middle of a write
        for (int i = 0; i < 3; i++) push(AW'(16'h0300 + i), DW'($urandom));
        wait_req(5, "t5_req_rise");
        @(posedge clk);
        #3;
        rst = 1'b1;
        mq.delete();
        exp_wr.delete();
        pop_pending = 0;
        #1;
        chk("t5_req_async", 64'(bus.mem_write_req), 64'(0));
        chk("t5_count", 64'(bus.count), 64'(0));
        chk("t5_empty", 64'(bus.empty), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        push(16'h0044, 32'h12345678);
        wait_empty(20, "t5_after_reset");
        bus.mem_ack = 1'b0;

        // randomized traffic over a small address set to force repeated matches
        for (int c = 0; c < 400; c++) begin
            bus.evict_valid    = 1'($urandom_range(0, 1));
            bus.evict_address  = AW'($urandom_range(0, 7));
            bus.evict_data     = DW'($urandom);
            bus.mem_ack        = ($urandom_range(0, 9) < 4);
            bus.lookup_address = AW'($urandom_range(0, 7));
            @(negedge clk);
        end
        bus.evict_valid = 1'b0;
        bus.mem_ack     = 1'b1;
        wait_empty(60, "rand_drain");
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_wr.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
